// File: rtl/adder_lane_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : adder_lane_arbiter
// Purpose  : Shares one 32-bit split-capable adder between two requesters.
//            Each requester issues a 32-bit add or a 16-bit add. Two 16-bit
//            adds can be packed into one split issue when their carries
//            allow it. One registered issue stage drives the adder. Each
//            result is captured into a per-requester response register with
//            a valid/ready handshake.
// Ports    : clk, rst_n                 - clock, async active-low reset
//            req_valid/ready[1:0]       - per-requester request handshake
//            req_mode/co_need/ci[1:0]   - 1=32-bit op / carry-out wanted / Ci
//            req_a0,req_b0,req_a1,req_b1 - operands (16-bit ops use [15:0])
//            add_a,add_b,add_ci,add_split - registered adder operands
//            add_s,add_co               - adder sum and high-half carry-out
//            rsp_valid/ready[1:0]       - per-requester response handshake
//            rsp_sum0,rsp_sum1,rsp_co   - captured results
// Revision : 1.0 - initial release
// ============================================================================
module adder_lane_arbiter #(
    parameter int PAIR_EN = 1,
    parameter bit RR_INIT = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [1:0]  req_mode,
    input  logic [1:0]  req_co_need,
    input  logic [1:0]  req_ci,
    input  logic [31:0] req_a0,
    input  logic [31:0] req_b0,
    input  logic [31:0] req_a1,
    input  logic [31:0] req_b1,
    output logic [31:0] add_a,
    output logic [31:0] add_b,
    output logic        add_ci,
    output logic        add_split,
    input  logic [31:0] add_s,
    input  logic        add_co,
    output logic [1:0]  rsp_valid,
    input  logic [1:0]  rsp_ready,
    output logic [31:0] rsp_sum0,
    output logic [31:0] rsp_sum1,
    output logic [1:0]  rsp_co
);

    // How each requester extracts its result from the adder output.
    localparam logic [1:0] c_SEL_FULL  = 2'd0; // 32-bit op: whole sum, add_co
    localparam logic [1:0] c_SEL_LO_CO = 2'd1; // single 16-bit: low sum, add_co
    localparam logic [1:0] c_SEL_LO    = 2'd2; // pair, low lane: low sum, co=0
    localparam logic [1:0] c_SEL_HI    = 2'd3; // pair, high lane: high sum, add_co

    logic [31:0] r_iss_a, r_iss_b;
    logic        r_iss_ci, r_iss_split;
    logic [1:0]  r_iss_own;
    logic [1:0]  r_iss_sel0, r_iss_sel1;
    logic        r_rr_ptr;
    logic [1:0]  r_rsp_valid;
    logic [31:0] r_rsp_sum0, r_rsp_sum1;
    logic [1:0]  r_rsp_co;

    logic [31:0] w_iss_a_nxt, w_iss_b_nxt;
    logic        w_iss_ci_nxt, w_iss_split_nxt;
    logic [1:0]  w_iss_sel0_nxt, w_iss_sel1_nxt;
    logic        w_rr_ptr_nxt;
    logic [1:0]  w_rsp_valid_nxt;
    logic [31:0] w_rsp_sum0_nxt, w_rsp_sum1_nxt;
    logic [1:0]  w_rsp_co_nxt;

    logic [1:0]  w_elig, w_grant;
    logic        w_both, w_r0_lo_ok, w_r1_lo_ok, w_pair;
    logic [31:0] w_one_a, w_one_b;
    logic        w_one_ci, w_one_mode;
    logic [32:0] w_res0, w_res1;

    function automatic logic [32:0] f_result(input logic [1:0]  sel,
                                             input logic [31:0] s,
                                             input logic        co);
        logic [32:0] res;
        case (sel)
            c_SEL_FULL:  res = {co, s};
            c_SEL_LO_CO: res = {co, 16'h0000, s[15:0]};
            c_SEL_LO:    res = {1'b0, 16'h0000, s[15:0]};
            default:     res = {co, 16'h0000, s[31:16]};
        endcase
        return res;
    endfunction

    // A requester is busy from accept until its response has been consumed;
    // rsp_valid is the registered value, so a same-cycle handshake frees the
    // slot only on the following cycle.
    always_comb begin
        w_elig     = req_valid & ~r_iss_own & ~r_rsp_valid;
        w_both     = w_elig[0] && w_elig[1];
        // Low lane may not need its carry-out (it is not chained out), and
        // the high lane must have Ci=0 (its carry-in is forced to 0).
        w_r0_lo_ok = !req_co_need[0] && !req_ci[1];
        w_r1_lo_ok = !req_co_need[1] && !req_ci[0];
        w_pair     = (PAIR_EN != 0) && w_both && !req_mode[0] && !req_mode[1]
                     && (w_r0_lo_ok || w_r1_lo_ok);
    end

    always_comb begin
        w_grant      = w_elig;
        w_rr_ptr_nxt = r_rr_ptr;
        if (w_both && !w_pair) begin
            w_grant      = r_rr_ptr ? 2'b10 : 2'b01;
            w_rr_ptr_nxt = ~r_rr_ptr;
        end
    end

    assign req_ready = w_grant;

    // Issue-register next state; an empty issue drives all zeros to the adder.
    always_comb begin
        w_iss_a_nxt     = '0;
        w_iss_b_nxt     = '0;
        w_iss_ci_nxt    = 1'b0;
        w_iss_split_nxt = 1'b0;
        w_iss_sel0_nxt  = c_SEL_FULL;
        w_iss_sel1_nxt  = c_SEL_FULL;
        w_one_a         = w_grant[1] ? req_a1 : req_a0;
        w_one_b         = w_grant[1] ? req_b1 : req_b0;
        w_one_ci        = w_grant[1] ? req_ci[1] : req_ci[0];
        w_one_mode      = w_grant[1] ? req_mode[1] : req_mode[0];
        if (w_pair) begin
            if (w_r0_lo_ok) begin
                w_iss_a_nxt    = {req_a1[15:0], req_a0[15:0]};
                w_iss_b_nxt    = {req_b1[15:0], req_b0[15:0]};
                w_iss_ci_nxt   = req_ci[0];
                w_iss_sel0_nxt = c_SEL_LO;
                w_iss_sel1_nxt = c_SEL_HI;
            end else begin
                w_iss_a_nxt    = {req_a0[15:0], req_a1[15:0]};
                w_iss_b_nxt    = {req_b0[15:0], req_b1[15:0]};
                w_iss_ci_nxt   = req_ci[1];
                w_iss_sel0_nxt = c_SEL_HI;
                w_iss_sel1_nxt = c_SEL_LO;
            end
        end else if (w_grant != 2'b00) begin
            w_iss_split_nxt = 1'b1;
            w_iss_ci_nxt    = w_one_ci;
            if (w_one_mode) begin
                w_iss_a_nxt    = w_one_a;
                w_iss_b_nxt    = w_one_b;
                w_iss_sel0_nxt = c_SEL_FULL;
            end else begin
                // High half FFFF+0 propagates the low-half carry to add_co.
                w_iss_a_nxt    = {16'hFFFF, w_one_a[15:0]};
                w_iss_b_nxt    = {16'h0000, w_one_b[15:0]};
                w_iss_sel0_nxt = c_SEL_LO_CO;
            end
            w_iss_sel1_nxt = w_iss_sel0_nxt;
        end
    end

    always_comb begin
        w_res0          = f_result(r_iss_sel0, add_s, add_co);
        w_res1          = f_result(r_iss_sel1, add_s, add_co);
        w_rsp_valid_nxt = r_rsp_valid & ~rsp_ready;
        w_rsp_sum0_nxt  = r_rsp_sum0;
        w_rsp_sum1_nxt  = r_rsp_sum1;
        w_rsp_co_nxt    = r_rsp_co;
        if (r_iss_own[0]) begin
            w_rsp_valid_nxt[0] = 1'b1;
            w_rsp_sum0_nxt     = w_res0[31:0];
            w_rsp_co_nxt[0]    = w_res0[32];
        end
        if (r_iss_own[1]) begin
            w_rsp_valid_nxt[1] = 1'b1;
            w_rsp_sum1_nxt     = w_res1[31:0];
            w_rsp_co_nxt[1]    = w_res1[32];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_iss_a     <= '0;
            r_iss_b     <= '0;
            r_iss_ci    <= 1'b0;
            r_iss_split <= 1'b0;
            r_iss_own   <= 2'b00;
            r_iss_sel0  <= c_SEL_FULL;
            r_iss_sel1  <= c_SEL_FULL;
            r_rr_ptr    <= RR_INIT;
            r_rsp_valid <= 2'b00;
            r_rsp_sum0  <= '0;
            r_rsp_sum1  <= '0;
            r_rsp_co    <= 2'b00;
        end else begin
            r_iss_a     <= w_iss_a_nxt;
            r_iss_b     <= w_iss_b_nxt;
            r_iss_ci    <= w_iss_ci_nxt;
            r_iss_split <= w_iss_split_nxt;
            r_iss_own   <= w_grant;
            r_iss_sel0  <= w_iss_sel0_nxt;
            r_iss_sel1  <= w_iss_sel1_nxt;
            r_rr_ptr    <= w_rr_ptr_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_sum0  <= w_rsp_sum0_nxt;
            r_rsp_sum1  <= w_rsp_sum1_nxt;
            r_rsp_co    <= w_rsp_co_nxt;
        end
    end

    assign add_a     = r_iss_a;
    assign add_b     = r_iss_b;
    assign add_ci    = r_iss_ci;
    assign add_split = r_iss_split;
    assign rsp_valid = r_rsp_valid;
    assign rsp_sum0  = r_rsp_sum0;
    assign rsp_sum1  = r_rsp_sum1;
    assign rsp_co    = r_rsp_co;

endmodule
`default_nettype wire

// File: tb/tb_adder_lane_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_adder_lane_arbiter
// Purpose  : Self-checking bench for adder_lane_arbiter. It models the shared
//            split adder, drives directed requests and queues hand-computed
//            responses. A monitor compares the responses at each handshake.
// Revision : 1.0 - initial release
// ============================================================================
module tb_adder_lane_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_valid, req_ready, req_mode, req_co_need, req_ci;
    logic [31:0] req_a0, req_b0, req_a1, req_b1;
    logic [31:0] add_a, add_b, add_s;
    logic        add_ci, add_split, add_co;
    logic [1:0]  rsp_valid, rsp_ready, rsp_co;
    logic [31:0] rsp_sum0, rsp_sum1;

    int n_checks = 0;
    int n_fail   = 0;
    logic [32:0] q0[$];
    logic [32:0] q1[$];

    always #5 clk = ~clk;

    adder_lane_arbiter #(.PAIR_EN(1), .RR_INIT(1'b0)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode),
        .req_co_need(req_co_need), .req_ci(req_ci),
        .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
        .add_a(add_a), .add_b(add_b), .add_ci(add_ci), .add_split(add_split),
        .add_s(add_s), .add_co(add_co),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_sum0(rsp_sum0), .rsp_sum1(rsp_sum1), .rsp_co(rsp_co)
    );

    // Shared split-capable adder: low half takes Ci; the high half chains
    // the low carry only when add_split=1.
    logic [16:0] w_lo, w_hi;
    assign w_lo   = {1'b0, add_a[15:0]} + {1'b0, add_b[15:0]} + {16'h0, add_ci};
    assign w_hi   = {1'b0, add_a[31:16]} + {1'b0, add_b[31:16]} + {16'h0, add_split & w_lo[16]};
    assign add_s  = {w_hi[15:0], w_lo[15:0]};
    assign add_co = w_hi[16];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Inputs change 2ns after a rising edge, so the falling edge sees the
    // values that the next rising edge will act on.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (rsp_valid[0] && rsp_ready[0]) begin
                if (q0.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL rsp0_unexpected: actual=valid sum=%h required=no response", rsp_sum0);
                end else
                    chk("rsp0_data", {31'b0, rsp_co[0], rsp_sum0}, {31'b0, q0.pop_front()});
            end
            if (rsp_valid[1] && rsp_ready[1]) begin
                if (q1.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL rsp1_unexpected: actual=valid sum=%h required=no response", rsp_sum1);
                end else
                    chk("rsp1_data", {31'b0, rsp_co[1], rsp_sum1}, {31'b0, q1.pop_front()});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drain();
        repeat (3) tick();
    endtask

    task automatic set_req(input int i, input logic mode, input logic co_need,
                           input logic ci, input logic [31:0] a, input logic [31:0] b);
        req_mode[i]    = mode;
        req_co_need[i] = co_need;
        req_ci[i]      = ci;
        if (i == 0) begin req_a0 = a; req_b0 = b; end
        else        begin req_a1 = a; req_b1 = b; end
    endtask

    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        logic [1:0] exp_rdy[5];
        exp_rdy = '{2'b01, 2'b10, 2'b00, 2'b01, 2'b10};
        rst_n = 1'b0; req_valid = 2'b00; req_mode = 2'b00; req_co_need = 2'b00;
        req_ci = 2'b00; req_a0 = '0; req_b0 = '0; req_a1 = '0; req_b1 = '0;
        rsp_ready = 2'b11;
        repeat (2) @(posedge clk);
        #2;
        chk("reset_add_a", add_a, 0);
        chk("reset_add_b", add_b, 0);
        chk("reset_ci_split", {add_ci, add_split}, 0);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_rsp_sums", {rsp_sum0, rsp_sum1}, 0);
        chk("reset_rsp_co", rsp_co, 0);
        rst_n = 1'b1;
        tick();

        // T1: 32-bit op on r0
        set_req(0, 1'b1, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001);
        req_valid = 2'b01; #1;
        chk("t1_ready", req_ready, 2'b01);
        q0.push_back({1'b1, 32'h0000_0000});
        tick(); req_valid = 2'b00; #1;
        chk("t1_add_a", add_a, 32'hFFFF_FFFF);
        chk("t1_add_b", add_b, 32'h0000_0001);
        chk("t1_ci_split", {add_ci, add_split}, 2'b01);
        chk("t1_rsp_early", rsp_valid, 2'b00);
        tick();
        chk("t1_rsp_valid", rsp_valid, 2'b01);
        tick();
        chk("t1_idle_adder", {add_split, add_a, add_b}, 0);
        chk("t1_rsp_consumed", rsp_valid, 2'b00);

        // T2: single 16-bit op on r1, upper operand bits must be ignored
        set_req(1, 1'b0, 1'b1, 1'b0, 32'h1234_FFFF, 32'hABCD_0001);
        req_valid = 2'b10; #1;
        chk("t2_ready", req_ready, 2'b10);
        q1.push_back({1'b1, 32'h0000_0000});
        tick(); req_valid = 2'b00; #1;
        chk("t2_add_a", add_a, 32'hFFFF_FFFF);
        chk("t2_add_b", add_b, 32'h0000_0001);
        chk("t2_ci_split", {add_ci, add_split}, 2'b01);
        tick();
        chk("t2_rsp_valid", rsp_valid, 2'b10);
        tick();

        // T3: pair with r0 in the low lane
        set_req(0, 1'b0, 1'b0, 1'b1, 32'hDEAD_1234, 32'hBEEF_1111);
        set_req(1, 1'b0, 1'b1, 1'b0, 32'h0000_F000, 32'h7777_2000);
        req_valid = 2'b11; #1;
        chk("t3_ready", req_ready, 2'b11);
        q0.push_back({1'b0, 32'h0000_2346});
        q1.push_back({1'b1, 32'h0000_1000});
        tick(); req_valid = 2'b00; #1;
        chk("t3_add_a", add_a, 32'hF000_1234);
        chk("t3_add_b", add_b, 32'h2000_1111);
        chk("t3_ci_split", {add_ci, add_split}, 2'b10);
        tick();
        chk("t3_rsp_valid", rsp_valid, 2'b11);
        tick();

        // T3b: pair with r1 in the low lane (r0 needs its carry-out)
        set_req(0, 1'b0, 1'b1, 1'b0, 32'h0000_8000, 32'h0000_8000);
        set_req(1, 1'b0, 1'b0, 1'b1, 32'h0000_0005, 32'h0000_0003);
        req_valid = 2'b11; #1;
        chk("t3b_ready", req_ready, 2'b11);
        q0.push_back({1'b1, 32'h0000_0000});
        q1.push_back({1'b0, 32'h0000_0009});
        tick(); req_valid = 2'b00; #1;
        chk("t3b_add_a", add_a, 32'h8000_0005);
        chk("t3b_add_b", add_b, 32'h8000_0003);
        chk("t3b_ci_split", {add_ci, add_split}, 2'b10);
        tick();
        chk("t3b_rsp_valid", rsp_valid, 2'b11);
        tick();

        // T4: non-pairable conflict, pointer still at 0 after the pairs
        set_req(0, 1'b0, 1'b1, 1'b0, 32'h5555_7FFF, 32'h0000_0001);
        set_req(1, 1'b0, 1'b1, 1'b1, 32'h0000_FFFF, 32'h0000_FFFF);
        req_valid = 2'b11;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk($sformatf("t4_ready_c%0d", c), req_ready, exp_rdy[c]);
            if (exp_rdy[c][0]) q0.push_back({1'b0, 32'h0000_8000});
            if (exp_rdy[c][1]) q1.push_back({1'b1, 32'h0000_FFFF});
            tick();
        end
        req_valid = 2'b00;
        drain();
        req_valid = 2'b11; #1;
        chk("t4_ptr_at_1", req_ready, 2'b10);
        q1.push_back({1'b1, 32'h0000_FFFF});
        tick(); req_valid = 2'b00;
        drain();
        req_valid = 2'b11; #1;
        chk("t4_ptr_at_0", req_ready, 2'b01);
        q0.push_back({1'b0, 32'h0000_8000});
        tick(); req_valid = 2'b00;
        drain();

        // T5: response back-pressure on r0
        rsp_ready = 2'b10;
        set_req(0, 1'b1, 1'b0, 1'b1, 32'h1234_5678, 32'h1111_1111);
        req_valid = 2'b01; #1;
        chk("t5_ready_first", req_ready, 2'b01);
        q0.push_back({1'b0, 32'h2345_678A});
        tick();
        set_req(0, 1'b1, 1'b0, 1'b0, 32'h0000_0001, 32'h0000_0001);
        tick();
        for (int c = 0; c < 5; c++) begin
            #1;
            chk($sformatf("t5_blocked_c%0d", c), req_ready[0], 1'b0);
            chk($sformatf("t5_hold_c%0d", c), {rsp_valid[0], rsp_sum0}, {1'b1, 32'h2345_678A});
            tick();
        end
        rsp_ready = 2'b11; #1;
        chk("t5_same_cycle", req_ready[0], 1'b0);
        tick(); #1;
        chk("t5_ready_after", req_ready, 2'b01);
        q0.push_back({1'b0, 32'h0000_0002});
        tick(); req_valid = 2'b00;
        drain();

        // T6: reset between accept and capture; pointer is 1 beforehand
        set_req(1, 1'b1, 1'b0, 1'b0, 32'h0000_0010, 32'h0000_0020);
        req_valid = 2'b10; #1;
        chk("t6_ready", req_ready, 2'b10);
        tick(); req_valid = 2'b00; #1;
        chk("t6_issued", add_split, 1'b1);
        rst_n = 1'b0; #1;
        chk("t6_rst_adder", {add_a, add_b, add_ci, add_split}, 0);
        chk("t6_rst_rsp", rsp_valid, 2'b00);
        @(posedge clk); #2;
        chk("t6_rst_held", {rsp_valid, add_split}, 0);
        rst_n = 1'b1;
        tick(); tick();
        chk("t6_no_stale", rsp_valid, 2'b00);
        set_req(0, 1'b0, 1'b1, 1'b0, 32'h0000_0001, 32'h0000_0002);
        set_req(1, 1'b0, 1'b1, 1'b0, 32'h0000_0003, 32'h0000_0004);
        req_valid = 2'b11; #1;
        chk("t6_ptr_init", req_ready, 2'b01);
        q0.push_back({1'b0, 32'h0000_0003});
        tick(); req_valid = 2'b00;
        drain();

        chk("end_q0_empty", q0.size(), 0);
        chk("end_q1_empty", q1.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
